// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Drives the program counter into the instruction memory. Fetched words go
// into a 2-entry in-order prefetch queue, and the decoder takes them over a
// valid/ready handshake. The unit also handles branch/jump redirects,
// halt/resume, and trapping on misaligned redirect targets.
//
// Optional feature macro: IFU_PERF_CNT_EN
//   When defined, the unit adds the free-running, wrapping performance
//   counters perf_fetch_cnt and perf_stall_cnt.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   imem_addr       address to instruction memory (the fetch_pc register)
//   imem_instr      combinational instruction word for imem_addr
//   redirect_valid  one-cycle request to restart fetch at redirect_pc
//   redirect_pc     new fetch address
//   halt            level; while high no new fetches are issued
//   out_valid       queue head valid
//   out_ready       decoder accepts the head when out_valid && out_ready
//   out_instr       head instruction word
//   out_pc          address the head word was fetched from
//   misalign_err    high while the unit is trapped on a misaligned target
//   perf_fetch_cnt  (IFU_PERF_CNT_EN) pushes into the queue
//   perf_stall_cnt  (IFU_PERF_CNT_EN) fetch-enabled cycles blocked by a full queue
//
// state   | meaning
// --------+-------------------------------------------------
// ST_RUN  | fetching whenever halt is low and the queue has room
// ST_HALT | no fetch; the queue drains to the decoder
// ST_ERR  | misaligned redirect seen; no fetch, queue empty
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [1:0]  count;
  // The second queue entry. The head entry lives directly in out_pc/out_instr.
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic        pop;
  logic        fetch_en;
  logic        push;
  logic        redirect_misaligned;

  assign imem_addr = fetch_pc;

  assign pop                 = out_valid && out_ready;
  assign fetch_en            = (state == ST_RUN) && !halt && !redirect_valid;
  // A full queue can still accept a word if the head leaves this cycle.
  assign push                = fetch_en && ((count != 2'd2) || pop);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      fetch_pc     <= RESET_PC;
      count        <= 2'd0;
      out_valid    <= 1'b0;
      out_pc       <= 32'h0;
      out_instr    <= 32'h0;
      tail_pc      <= 32'h0;
      tail_instr   <= 32'h0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // A redirect flushes the queue. A pop in the same cycle is still
      // accepted by the decoder, but the queue is emptied regardless.
      // The head data is left in place because it is don't-care while
      // out_valid is low.
      fetch_pc  <= redirect_pc;
      count     <= 2'd0;
      out_valid <= 1'b0;
      if (redirect_misaligned) begin
        state        <= ST_ERR;
        misalign_err <= 1'b1;
      end else begin
        misalign_err <= 1'b0;
        state        <= (state == ST_HALT) ? ST_HALT : ST_RUN;
      end
    end else begin
      case (state)
        ST_RUN:  if (halt)  state <= ST_HALT;
        ST_HALT: if (!halt) state <= ST_RUN;
        default: state <= state;
      endcase

      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      case ({push, pop})
        2'b10: begin
          // A push without a pop only happens with 0 or 1 entries.
          if (count == 2'd0) begin
            out_pc    <= fetch_pc;
            out_instr <= imem_instr;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end else begin
            tail_pc    <= fetch_pc;
            tail_instr <= imem_instr;
            count      <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            out_pc    <= tail_pc;
            out_instr <= tail_instr;
            count     <= 2'd1;
          end else begin
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        2'b11: begin
          // Count is unchanged. The new word goes to whichever slot is
          // now last in line.
          if (count == 2'd2) begin
            out_pc     <= tail_pc;
            out_instr  <= tail_instr;
            tail_pc    <= fetch_pc;
            tail_instr <= imem_instr;
          end else begin
            out_pc    <= fetch_pc;
            out_instr <= imem_instr;
          end
        end
        default: count <= count;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      // Fetch was wanted, but the queue is full and no pop freed a slot.
      if (fetch_en && !push) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign_err   (misalign_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word k holds (k+1)*0x11, so words 0..3 are 0x11,0x22,0x33,0x44.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // Behavioural reference model.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  localparam int M_RUN = 0;
  localparam int M_HALT = 1;
  localparam int M_ERR = 2;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_mode;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0;
    m_mode = M_RUN;
    m_fetch = 32'h0;
    m_stall = 32'h0;
  endtask

  task automatic model_edge(input bit rv, input logic [31:0] rpc, input bit h, input bit rdy);
    bit pop;
    bit want;
    bit push;
    ent_t e;
    pop  = (mq.size() > 0) && rdy;
    want = (m_mode == M_RUN) && !h && !rv;
    push = want && ((mq.size() < 2) || pop);
    if (pop) e = mq.pop_front();
    if (rv) begin
      mq.delete();
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) m_mode = M_ERR;
      else if (m_mode != M_HALT) m_mode = M_RUN;
    end else begin
      if (push) begin
        e.pc = m_pc;
        e.instr = mem_word(m_pc);
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
      end else if (want) begin
        m_stall = m_stall + 32'd1;
      end
      if (m_mode == M_RUN && h) m_mode = M_HALT;
      else if (m_mode == M_HALT && !h) m_mode = M_RUN;
    end
  endtask

  // Holds the inputs for one cycle, steps the model at the edge, then returns
  // just after the edge.
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit h, input bit rdy);
    redirect_valid = rv;
    redirect_pc = rpc;
    halt = h;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rv, rpc, h, rdy);
    #2;
  endtask

  // Compare process: every negedge the DUT must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {31'h0, out_valid}, {31'h0, (mq.size() != 0)});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, (m_mode == M_ERR)});
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_instr", out_instr, mq[0].instr);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
      chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_misalign_err"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    bit h_r;
    bit rv_r;
    logic [31:0] rpc_r;

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset and stream.
    cyc(0, 0, 0, 1);
    chk("stream0_pc", out_pc, 32'h0);
    chk("stream0_instr", out_instr, 32'h11);
    cyc(0, 0, 0, 1);
    chk("stream1_pc", out_pc, 32'h4);
    chk("stream1_instr", out_instr, 32'h22);
    cyc(0, 0, 0, 1);
    chk("stream2_pc", out_pc, 32'h8);
    chk("stream2_instr", out_instr, 32'h33);
    cyc(0, 0, 0, 1);
    chk("stream3_pc", out_pc, 32'hC);
    chk("stream3_instr", out_instr, 32'h44);

    // Async reset between edges.
    #1;
    rst = 1'b1;
    chk_en = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Backpressure.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("bp_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_pc_held", out_pc, 32'h0);
    chk("bp_imem_addr", imem_addr, 32'h8);
`ifdef IFU_PERF_CNT_EN
    chk("bp_perf_fetch", perf_fetch_cnt, 32'd2);
    chk("bp_perf_stall", perf_stall_cnt, 32'd3);
`endif
    cyc(0, 0, 0, 1);
    chk("bp_rel0_pc", out_pc, 32'h4);
    cyc(0, 0, 0, 1);
    chk("bp_rel1_pc", out_pc, 32'h8);

    // Redirect with 2 entries queued (0x8, 0xC).
    cyc(1, 32'h40, 0, 1);
    chk("redir_bubble_valid", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("redir_target_valid", {31'h0, out_valid}, 32'h1);
    chk("redir_target_pc", out_pc, 32'h40);
    chk("redir_target_instr", out_instr, 32'h121);
    cyc(0, 0, 0, 1);
    chk("redir_next_pc", out_pc, 32'h44);

    // Misaligned redirect.
    cyc(1, 32'h42, 0, 1);
    chk("mis_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_valid", {31'h0, out_valid}, 32'h0);
    chk("mis_addr", imem_addr, 32'h42);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("mis_hold_err", {31'h0, misalign_err}, 32'h1);
    chk("mis_hold_valid", {31'h0, out_valid}, 32'h0);
    cyc(1, 32'h80, 0, 1);
    chk("mis_clear_err", {31'h0, misalign_err}, 32'h0);
    chk("mis_clear_valid", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("mis_recover_pc", out_pc, 32'h80);
    chk("mis_recover_instr", out_instr, 32'h231);

    // Halt, drain, redirect while halted, wrap.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("halt_head_pc", out_pc, 32'h80);
    cyc(0, 0, 1, 1);
    chk("halt_drain_pc", out_pc, 32'h84);
    cyc(0, 0, 1, 1);
    chk("halt_empty", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 1, 1);
    chk("halt_addr_stopped", imem_addr, 32'h88);
    cyc(1, 32'hFFFF_FFFC, 1, 1);
    chk("halt_redir_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("resume_no_push", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("wrap0_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap0_instr", out_instr, 32'h4000_0000);
    cyc(0, 0, 0, 1);
    chk("wrap1_pc", out_pc, 32'h0);
    chk("wrap1_instr", out_instr, 32'h11);
    chk("wrap1_addr", imem_addr, 32'h4);

    // Randomized traffic against the model.
    h_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rv_r = ($urandom_range(0, 15) == 0);
      rpc_r = $urandom;
      if ($urandom_range(0, 3) != 0) rpc_r[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc_r = 32'hFFFF_FFF8;
      if ($urandom_range(0, 9) == 0) h_r = !h_r;
      cyc(rv_r, rpc_r, h_r, ($urandom_range(0, 9) < 7));
    end

    cyc(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
